// File: rtl/fifo_pkg.sv
// Constants and helpers shared by the async FIFO and its write-side packer.
package fifo_pkg;

  localparam int FIFO_DATA_SIZE = 8;
  localparam int FIFO_ADDR_SIZE = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_packer_if.sv
// Source beat stream and FIFO write port seen by the write-side packer.
interface fifo_wr_packer_if
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = FIFO_DATA_SIZE,
  parameter int IN_SIZE   = 2
);

  logic [IN_SIZE-1:0]   s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;
  logic [DATA_SIZE-1:0] wdata;
  logic                 wput;
  logic                 wfull;

  modport slave (
    input  s_data, s_valid, s_last, wfull,
    output s_ready, wdata, wput
  );

  modport master (
    output s_data, s_valid, s_last, wfull,
    input  s_ready, wdata, wput
  );

endinterface

// File: rtl/fifo_wr_packer.sv
// Packs narrow source beats into FIFO words, zero-padding short frames.
module fifo_wr_packer
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = FIFO_DATA_SIZE,
  parameter int IN_SIZE   = 2,
  parameter int CNT_SIZE  = 16
) (
  input  logic                wclk,
  input  logic                wrst_n,
  fifo_wr_packer_if.slave     bus,
  output logic [CNT_SIZE-1:0] frame_cnt,
  output logic                stall
);

  localparam int RATIO    = DATA_SIZE / IN_SIZE;
  localparam int IDX_RAW  = clog2(RATIO);
  localparam int IDX_SIZE = (IDX_RAW < 1) ? 1 : IDX_RAW;
  localparam logic [IDX_SIZE-1:0] LAST_IDX =
    IDX_SIZE'(RATIO - 1);

  logic [DATA_SIZE-1:0] acc;
  logic [DATA_SIZE-1:0] merged;
  logic [IDX_SIZE-1:0]  idx;
  logic [IN_SIZE-1:0]   beat;
  logic                 accept;
  logic                 last;
  logic                 complete;
  logic                 drain;

  // Conservative: any pending word blocked by wfull stops intake.
  assign bus.s_ready = !bus.wput || !bus.wfull;
  assign stall       = bus.s_valid && !bus.s_ready;

  assign accept   = bus.s_valid && bus.s_ready;
  assign beat     = accept ? bus.s_data : '0;
  assign last     = accept && bus.s_last;
  assign complete = accept && ((idx == LAST_IDX) || bus.s_last);
  assign drain    = bus.wput && !bus.wfull;

  always_comb begin
    merged = acc;
    for (int i = 0; i < RATIO; i++)
      if (idx == IDX_SIZE'(i))
        merged[i*IN_SIZE +: IN_SIZE] = beat;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      acc       <= '0;
      idx       <= '0;
      bus.wdata <= '0;
      bus.wput  <= 1'b0;
    end else begin
      if (complete) begin
        bus.wdata <= merged;
        bus.wput  <= 1'b1;
        acc       <= '0;
        idx       <= '0;
      end else begin
        if (accept) begin
          acc <= merged;
          idx <= idx + IDX_SIZE'(1);
        end
        if (drain)
          bus.wput <= 1'b0;
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)
      frame_cnt <= '0;
    else if (last)
      frame_cnt <= frame_cnt + CNT_SIZE'(1);
  end

endmodule
